// File: rtl/trig_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : trig_bank                                                   |
// | Description: Bank of WIDTH single-bit triggers sharing clock, reset,     |
// |              enable and a run-time trigger type (T, D, JK, SR). When     |
// |              TRIG_CHAIN_EN is defined, T mode can cascade the channels   |
// |              into a synchronous binary up-counter with a wrap pulse.     |
// |              Optional macro: TRIG_CHAIN_EN                                |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module trig_bank #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             chain,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nq,
  output logic             wrap,
  output logic             err
);

  localparam logic [1:0] MODE_T  = 2'b00;
  localparam logic [1:0] MODE_D  = 2'b01;
  localparam logic [1:0] MODE_JK = 2'b10;
  localparam logic [1:0] MODE_SR = 2'b11;

  logic [WIDTH-1:0] t_eff;
  logic [WIDTH-1:0] q_next;
  logic             sr_illegal;

`ifdef TRIG_CHAIN_EN
  logic chain_on;
  logic wrap_next;

  assign chain_on = chain && (mode == MODE_T);

  // Toggle enables: plain a, or a running AND of a[0] and all lower q bits
  // when cascaded, so the bank increments as a binary counter.
  always_comb begin
    logic run;
    run   = a[0];
    t_eff = a;
    if (chain_on) begin
      for (int i = 0; i < WIDTH; i++) begin
        t_eff[i] = run;
        run      = run & q[i];
      end
    end
  end

  // Roll-over is an increment of an all-ones count.
  assign wrap_next = chain_on && en && !clr && a[0] && (&q);

  // One-cycle wrap pulse; dropped by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap <= 1'b0;
    end else begin
      wrap <= wrap_next;
    end
  end
`else
  logic chain_unused;

  // Chain port kept for interface stability but has no effect here.
  assign chain_unused = chain;
  assign t_eff        = a;
  assign wrap         = 1'b0;
`endif

  // Per-channel next state for the selected trigger type.
  always_comb begin
    q_next     = q;
    sr_illegal = 1'b0;
    case (mode)
      MODE_T:  q_next = q ^ t_eff;
      MODE_D:  q_next = a;
      // J sets when q=0, K clears when q=1; J=K=1 toggles.
      MODE_JK: q_next = (a & ~q) | (~b & q);
      // S=1,R=0 sets; S=0,R=1 clears; 00 and the illegal 11 hold.
      default: begin
        q_next     = (a & ~b) | (q & ~(a ^ b));
        sr_illegal = |(a & b);
      end
    endcase
  end

  // State and sticky error register: reset, then clr, then enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q   <= INIT;
      err <= 1'b0;
    end else if (clr) begin
      q   <= INIT;
      err <= 1'b0;
    end else if (en) begin
      q   <= q_next;
      err <= err | sr_illegal;
    end
  end

  assign nq = ~q;

endmodule
`default_nettype wire

// File: doc/trig_bank.md
# trig_bank

Parametrised bank of WIDTH independent single-bit triggers with a run-time selectable type: T, D, JK or SR. All channels share clock, reset, enable and mode. An optional chain mode cascades the T triggers into a synchronous binary up-counter with a wrap pulse. It is the multi-channel, multi-mode successor to the single T trigger in the triggers library and is driven directly by the triggers testbenches.

## Interface
- WIDTH, 4, number of trigger channels (≥1)
- INIT, {WIDTH{1'b0}}, value loaded into q on reset and on clr
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- en  in  1  global clock enable; q holds when 0
- clr  in  1  synchronous clear to INIT; ignores en
- mode  in  2  trigger type: 00 T, 01 D, 10 JK, 11 SR
- a  in  WIDTH  per-channel T / D / J / S input
- b  in  WIDTH  per-channel K / R input; ignored in T and D modes
- chain  in  1  cascade select; honoured only in T mode with TRIG_CHAIN_EN
- q  out  WIDTH  trigger state
- nq  out  WIDTH  ~q, combinational
- wrap  out  1  one-cycle pulse after the chain counter rolls over
- err  out  1  sticky flag: SR S=R=1 seen

## Operation
- Reset (rst=0): q=INIT, nq=~INIT, wrap=0, err=0. Applies immediately, without a clock edge, and wins over every other input.
- Priority at each rising edge: clr, then en, then mode.
- clr=1:
  - q←INIT, wrap←0, err←0, regardless of en.
- en=1, clr=0, per channel i:
  - T: q[i]←q[i]^t_eff[i].
  - D: q[i]←a[i].
  - JK: 00 hold, 01 reset to 0, 10 set to 1, 11 toggle, using {a[i],b[i]}.
  - SR: 00 hold, 01 reset to 0, 10 set to 1, using {a[i],b[i]}. 11 is illegal: q[i] holds and err←1.
- en=0, clr=0: q, err and wrap hold, except wrap returns to 0 after its single cycle.
- T-mode toggle enable t_eff:
  - Chain off: t_eff=a.
  - Chain on: t_eff[0]=a[0] and t_eff[i]=t_eff[i-1]&q[i-1]. a[WIDTH-1:1] are ignored, so the bank counts up by one per enabled edge while a[0]=1.
- wrap←1 for exactly one cycle after an edge at which chain is active, en=1, a[0]=1 and q is all-ones, so q goes to all-zeros. Otherwise wrap←0.
- err is cleared only by rst or clr.
- mode, a, b and chain are sampled at the edge. A mode change takes effect at the same edge; there is no transition state.

## Timing
- q, wrap and err are registered, with 1-cycle latency from the sampling edge.
- nq follows q combinationally with zero latency.
- Asynchronous reset assertion is immediate. Deassertion is synchronous to the design; the first update occurs at the first rising edge with rst=1.
- Reset asserted mid-count: the count is lost, q=INIT, and a pending wrap is dropped.
- clr and en together: clr wins, q=INIT.
- WIDTH=1 in chain mode: the bank toggles per edge and wrap pulses on every 1→0 transition.
- Chain counting with INIT≠0 starts from INIT. Wrap is still defined by the all-ones → all-zeros transition.
- SR 11 on several channels in one cycle: each affected channel holds and err is set once.

## Configuration
- TRIG_CHAIN_EN defined: the cascade logic and wrap register are compiled in, and the chain input behaves as described above.
- TRIG_CHAIN_EN undefined:
  - The chain port remains for interface stability but is ignored.
  - T mode always uses t_eff=a.
  - wrap is tied to 0.

## Test plan
All scenarios use WIDTH=4, INIT=0000.
- Reset: drop rst between clock edges while q=1010 → q=0000, nq=1111, wrap=0, err=0 with no edge. The first edge after release with mode=T, a=0001, en=1 → q=0001.
- T mode: a=0101, en=1 for 3 edges → q=0101, 0000, 0101. With en=0 on a 4th edge → q stays 0101.
- JK mode: from q=0000, a=1100, b=1010 → q=1100. Repeating the same inputs → q=0100, since bit 3 toggles and bit 2 stays set.
- SR mode: a=0001, b=0001 from q=0000 → q=0000, err=1 next cycle. err stays 1 through 5 more edges and returns to 0 after clr=1.
- Chain mode (TRIG_CHAIN_EN): mode=T, chain=1, a=0001, 16 edges → q=0001…1111, 0000. wrap=1 only in the cycle after q becomes 0000. Holding en=0 on one edge mid-count freezes q. With the macro undefined, the same stimulus gives q toggling 0001/0000 and wrap=0 throughout.
- clr priority: q=0110, clr=1 with en=1, mode=D, a=1111 → q=0000, wrap=0, err=0.
